rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port between two write-back requesters: the multicycle datapath (req0) and the memory-return/load path (req1). Runs a post-reset clear sequence that zeroes $1..$31, then grants one write per cycle with round-robin fairness and drops writes to $0. All register-file drive signals are registered, so the write port sees clean, clock-aligned strobes instead of data-change-triggered updates.

## Interface
- CLEAR_ON_RESET, 1: 1 runs the $1..$31 zeroing sequence after reset; 0 skips it.
- clk  in  1  rising-edge clock; one clock, no other domains.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  datapath write request.
- req0_rd  in  5  destination register.
- req0_data  in  32  write data.
- req0_ready  out  1  combinational grant; transfer when valid&ready at an edge.
- req1_valid / req1_rd / req1_data / req1_ready: same as req0, for the load path.
- rf_we  out  1  registered write strobe to the register file.
- rf_rd  out  5  registered write address.
- rf_wdata  out  32  registered write data.
- init_done  out  1  registered; high once the clear sequence has finished.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with cnt=1 if CLEAR_ON_RESET=1, else RUN.
- CLEAR: each edge registers rf_we=1, rf_rd=cnt, rf_wdata=0, then cnt++. At cnt=31 the edge also moves to RUN and sets init_done=1. Both readies are 0 throughout.
- RUN, grant rules:
  - Neither valid: no grant, rf_we<=0.
  - One valid: grant that requester.
  - Both valid: grant the requester named by prio. prio resets to 0 (req0 first).
  - After any grant, prio<=the other requester, including grants to $0.
- Granted write with rd!=0: rf_we<=1, rf_rd<=rd, rf_wdata<=data.
- Granted write with rd==0: ready still asserts (request consumed), but rf_we<=0 and rf_rd/rf_wdata hold their values.
- A requester keeps valid, rd and data stable until ready. Ungranted requests wait with no loss.
- Reset mid-sequence or mid-write: the next edge forces reset values, discards the in-flight write and restarts CLEAR.
- Same-cycle equal rd from both requesters: the two are serialized by arbitration, so the later grant's data wins in the register file.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, init_done=0, req0_ready=0, req1_ready=0, prio=0, cnt=1.
- CLEAR_ON_RESET=1: rf_we is high for exactly 31 cycles, after edges 1..31 following rst release. init_done rises after edge 31, and readies may assert in that same cycle.
- CLEAR_ON_RESET=0: init_done rises after edge 1.
- Latency: a request granted at edge N appears on rf_* after edge N and is written at edge N+1.
- Throughput: one grant per cycle. With both requesters continuously valid, grants alternate every cycle.
- readyX depends only on state, prio and both valids. It never depends on rd or data.

## Structure
- Shared package rf_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - state typedef {CLEAR, RUN}.
  - ZERO_REG=5'd0.
- Sub-module rr_arb2: 2-way round-robin grant from valids plus a prio flop, with a combinational grant output. The arbiter top holds the FSM, clear counter and output registers.

## Test plan
- Release rst with CLEAR_ON_RESET=1 -> rf_we=1 with rf_rd=1..31 on consecutive cycles, rf_wdata=0 throughout; init_done=1 after edge 31; readies 0 until then.
- After init, req0 {rd=5, data=0xDEADBEEF} alone -> req0_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Both valid continuously: req0 rd=2 and req1 rd=3, for 4 cycles -> grants go req0, req1, req0, req1; rf_rd sequence 2, 3, 2, 3.
- req1 {rd=0, data=0x1234} -> req1_ready=1; rf_we stays 0; prio flips so a following simultaneous request grants req0.
- Assert rst for one cycle while both requesters are valid mid-run -> all outputs return to reset values; the CLEAR sequence restarts from rf_rd=1; no stale grant afterwards.
- CLEAR_ON_RESET=0 -> init_done=1 after one edge; no clear writes; a request in the next cycle is granted immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, FSM state type and constants for the register-file write arbiter.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [REG_ADDR_W-1:0] LAST_REG = 5'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the valids and a
// priority flop that points at the requester that lost (or waited) last.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic prio_reg;

    always_comb begin
        grant0 = en && valid0 && (!valid1 || !prio_reg);
        grant1 = en && valid1 && (!valid0 ||  prio_reg);
    end

    // Any grant, including one to $0, hands priority to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (grant0) begin
            prio_reg <= 1'b1;
        end else if (grant1) begin
            prio_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: post-reset clear of $1..$31, then one
// round-robin granted write per cycle with all rf_* outputs registered.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  init_done
);

    state_t                state_reg;
    logic [REG_ADDR_W-1:0] cnt_reg;
    logic                  rf_we_reg;
    logic [REG_ADDR_W-1:0] rf_rd_reg;
    logic [DATA_W-1:0]     rf_wdata_reg;
    logic                  init_done_reg;

    logic                  grant0;
    logic                  grant1;
    logic                  arb_en;
    logic [REG_ADDR_W-1:0] sel_rd_next;
    logic [DATA_W-1:0]     sel_data_next;

    // Readies are held low while rst is asserted so no request is consumed
    // by an edge that will discard the write anyway.
    assign arb_en = (state_reg == RUN) && !rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        sel_rd_next   = req0_rd;
        sel_data_next = req0_data;
        if (grant1) begin
            sel_rd_next   = req1_rd;
            sel_data_next = req1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_reg       <= 5'd1;
            rf_we_reg     <= 1'b0;
            rf_rd_reg     <= ZERO_REG;
            rf_wdata_reg  <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    rf_we_reg    <= 1'b1;
                    rf_rd_reg    <= cnt_reg;
                    rf_wdata_reg <= '0;
                    cnt_reg      <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_REG) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                RUN: begin
                    init_done_reg <= 1'b1;
                    rf_we_reg     <= 1'b0;
                    // Writes to $0 are consumed but leave address/data untouched.
                    if ((grant0 || grant1) && (sel_rd_next != ZERO_REG)) begin
                        rf_we_reg    <= 1'b1;
                        rf_rd_reg    <= sel_rd_next;
                        rf_wdata_reg <= sel_data_next;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_we      = rf_we_reg;
    assign rf_rd      = rf_rd_reg;
    assign rf_wdata   = rf_wdata_reg;
    assign init_done  = init_done_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: clear sequence, single writes,
// alternation, $0 drops, mid-run reset and the no-clear variant.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_rd, req1_rd;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we, init_done;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    logic        nc_rst;
    logic        nc_req0_valid, nc_req1_valid;
    logic [4:0]  nc_req0_rd, nc_req1_rd;
    logic [31:0] nc_req0_data, nc_req1_data;
    logic        nc_req0_ready, nc_req1_ready;
    logic        nc_rf_we, nc_init_done;
    logic [4:0]  nc_rf_rd;
    logic [31:0] nc_rf_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    rf_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rst(nc_rst),
        .req0_valid(nc_req0_valid), .req0_rd(nc_req0_rd), .req0_data(nc_req0_data), .req0_ready(nc_req0_ready),
        .req1_valid(nc_req1_valid), .req1_rd(nc_req1_rd), .req1_data(nc_req1_data), .req1_ready(nc_req1_ready),
        .rf_we(nc_rf_we), .rf_rd(nc_rf_rd), .rf_wdata(nc_rf_wdata), .init_done(nc_init_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        chk("reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset init_done", {31'd0, init_done}, 32'd0);
        chk("reset readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        $display("reset: rf_we=%0d rf_rd=%0d init_done=%0d", rf_we, rf_rd, init_done);
    endtask

    task automatic test_clear();
        // req0 waits through the whole clear; it must not be granted early.
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0000_0777;
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            step();
            chk($sformatf("clear%0d rf_we", i), {31'd0, rf_we}, 32'd1);
            chk($sformatf("clear%0d rf_rd", i), {27'd0, rf_rd}, i);
            chk($sformatf("clear%0d rf_wdata", i), rf_wdata, 32'd0);
            chk($sformatf("clear%0d init_done", i), {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
            chk($sformatf("clear%0d req0_ready", i), {31'd0, req0_ready}, (i == 31) ? 32'd1 : 32'd0);
            $display("clear edge %0d: rf_we=%0d rf_rd=%0d init_done=%0d ready0=%0d",
                     i, rf_we, rf_rd, init_done, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        chk("post-clear write we", {31'd0, rf_we}, 32'd1);
        chk("post-clear write rd", {27'd0, rf_rd}, 32'd7);
        chk("post-clear write data", rf_wdata, 32'h0000_0777);
        $display("post-clear write: rf_rd=%0d rf_wdata=0x%0h", rf_rd, rf_wdata);
        step();
        chk("idle rf_we", {31'd0, rf_we}, 32'd0);
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        chk("single req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("single req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        chk("single rf_we", {31'd0, rf_we}, 32'd1);
        chk("single rf_rd", {27'd0, rf_rd}, 32'd5);
        chk("single rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        $display("single: rf_we=%0d rf_rd=%0d rf_wdata=0x%0h", rf_we, rf_rd, rf_wdata);
        step();
        chk("single after rf_we", {31'd0, rf_we}, 32'd0);
    endtask

    task automatic test_zero_write();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
        #1;
        chk("zero req1_ready", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        chk("zero rf_we", {31'd0, rf_we}, 32'd0);
        chk("zero rf_rd hold", {27'd0, rf_rd}, 32'd5);
        chk("zero rf_wdata hold", rf_wdata, 32'hDEAD_BEEF);
        $display("zero write: rf_we=%0d rf_rd=%0d rf_wdata=0x%0h", rf_we, rf_rd, rf_wdata);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h0000_00A0;
        req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'h0000_00B1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("b2b%0d ready", k), {30'd0, req1_ready, req0_ready},
                (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            exp_rd   = (k % 2 == 0) ? 5'd2 : 5'd3;
            exp_data = (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
            chk($sformatf("b2b%0d rf_we", k), {31'd0, rf_we}, 32'd1);
            chk($sformatf("b2b%0d rf_rd", k), {27'd0, rf_rd}, {27'd0, exp_rd});
            chk($sformatf("b2b%0d rf_wdata", k), rf_wdata, exp_data);
            $display("b2b grant %0d: rf_rd=%0d rf_wdata=0x%0h", k, rf_rd, rf_wdata);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int budget;
        req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'h2222_2222;
        rst = 1'b1;
        #1;
        chk("midrst readies during rst", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("midrst rf_we", {31'd0, rf_we}, 32'd0);
        chk("midrst rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("midrst rf_wdata", rf_wdata, 32'd0);
        chk("midrst init_done", {31'd0, init_done}, 32'd0);
        rst = 1'b0;
        step();
        chk("midrst clear1 rf_we", {31'd0, rf_we}, 32'd1);
        chk("midrst clear1 rf_rd", {27'd0, rf_rd}, 32'd1);
        chk("midrst clear readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        $display("mid reset: restarted clear rf_rd=%0d", rf_rd);
        req0_valid = 1'b0; req1_valid = 1'b0;
        budget = 0;
        while (!init_done && budget < 100) begin
            step();
            budget++;
        end
        chk("midrst init_done in budget", {31'd0, init_done}, 32'd1);
        chk("midrst last clear rd", {27'd0, rf_rd}, 32'd31);
        step();
        chk("midrst no stale grant", {31'd0, rf_we}, 32'd0);
        $display("mid reset: init after %0d edges, rf_we=%0d", budget + 1, rf_we);
    endtask

    task automatic test_no_clear();
        nc_rst = 1'b1;
        step();
        chk("nc reset init_done", {31'd0, nc_init_done}, 32'd0);
        nc_rst = 1'b0;
        step();
        chk("nc init_done", {31'd0, nc_init_done}, 32'd1);
        chk("nc no clear write", {31'd0, nc_rf_we}, 32'd0);
        nc_req0_valid = 1'b1; nc_req0_rd = 5'd4; nc_req0_data = 32'h0000_0055;
        #1;
        chk("nc req0_ready", {31'd0, nc_req0_ready}, 32'd1);
        step();
        nc_req0_valid = 1'b0;
        chk("nc rf_we", {31'd0, nc_rf_we}, 32'd1);
        chk("nc rf_rd", {27'd0, nc_rf_rd}, 32'd4);
        chk("nc rf_wdata", nc_rf_wdata, 32'h0000_0055);
        $display("no clear: rf_we=%0d rf_rd=%0d rf_wdata=0x%0h", nc_rf_we, nc_rf_rd, nc_rf_wdata);
    endtask

    initial begin
        rst = 1'b1; nc_rst = 1'b1;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        nc_req0_valid = 1'b0; nc_req0_rd = '0; nc_req0_data = '0;
        nc_req1_valid = 1'b0; nc_req1_rd = '0; nc_req1_data = '0;
        test_reset();
        test_clear();
        test_single();
        test_zero_write();
        test_back_to_back();
        test_reset_mid();
        test_no_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
